// File: rtl/dcm_sched_pkg.sv
// Shared state encoding, multiplier types and the clamp helper for the DCM ramp scheduler.
package dcm_sched_pkg;
    localparam int MULT_W = 8;

    typedef logic [MULT_W-1:0] mult_t;
    typedef logic [MULT_W:0]   wide_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_STEP      = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_SETTLE    = 3'd4;
    localparam logic [2:0] ST_HALT      = 3'd5;

    function automatic mult_t clamp_mult(input mult_t v, input mult_t lo, input mult_t hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction
endpackage

// File: rtl/dcm_ramp_scheduler_if.sv
// Command, programmer-handshake and status signals of the DCM ramp scheduler.
interface dcm_ramp_scheduler_if;
    import dcm_sched_pkg::*;

    mult_t target_mult_i;
    logic  target_valid_i;
    logic  prog_busy_i;
    logic  dcm_locked_i;
    logic  hw_error_i;
    mult_t prog_multiplier_o;
    logic  prog_ready_o;
    mult_t current_multiplier_o;
    mult_t ceiling_o;
    logic  busy_o;
    logic  fault_o;

    modport slave (
        input  target_mult_i, target_valid_i, prog_busy_i, dcm_locked_i, hw_error_i,
        output prog_multiplier_o, prog_ready_o, current_multiplier_o, ceiling_o, busy_o, fault_o
    );

    modport master (
        output target_mult_i, target_valid_i, prog_busy_i, dcm_locked_i, hw_error_i,
        input  prog_multiplier_o, prog_ready_o, current_multiplier_o, ceiling_o, busy_o, fault_o
    );
endinterface

// File: rtl/dcm_error_window.sv
// Free-running error window plus a saturating hw_error counter; limit_hit_o flags a cluster.
module dcm_error_window #(
    parameter int unsigned ERROR_LIMIT  = 4,
    parameter int unsigned ERROR_WINDOW = 65536
) (
    input  logic clk,
    input  logic reset,
    input  logic hw_error_i,
    input  logic clear_count_i,
    output logic limit_hit_o
);
    localparam int WIN_W = (ERROR_WINDOW > 1) ? $clog2(ERROR_WINDOW) : 1;
    localparam int CNT_W = $clog2(ERROR_LIMIT + 1);

    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;

    assign wrap = (win_q == WIN_W'(ERROR_WINDOW - 1));
    assign win_d = wrap ? '0 : win_q + WIN_W'(1);

    // An error landing on the wrap cycle belongs to the new window.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_count_i)
            cnt_d = '0;
        else if (wrap)
            cnt_d = hw_error_i ? CNT_W'(1) : '0;
        else if (hw_error_i && cnt_q != CNT_W'(ERROR_LIMIT))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q <= '0;
            cnt_q <= '0;
        end else begin
            win_q <= win_d;
            cnt_q <= cnt_d;
        end
    end

    assign limit_hit_o = (cnt_q == CNT_W'(ERROR_LIMIT));
endmodule

// File: rtl/dcm_ramp_scheduler.sv
// Walks the DCM multiplier toward a requested target in bounded steps, backing off on error clusters.
// state     | meaning
// IDLE      | current == target, nothing to do
// STEP      | compute next multiplier, raise prog_ready
// WAIT_ACK  | prog_ready held until programmer shows busy
// WAIT_DONE | waiting for busy low with DCM locked
// SETTLE    | dwell after a completed step
// HALT      | programming timed out; only reset leaves
module dcm_ramp_scheduler
    import dcm_sched_pkg::*;
#(
    parameter int unsigned MAXIMUM_MULTIPLIER = 128,
    parameter int unsigned MINIMUM_MULTIPLIER = 20,
    parameter int unsigned INITIAL_MULTIPLIER = 60,
    parameter int unsigned STEP_SIZE          = 2,
    parameter int unsigned SETTLE_CYCLES      = 1024,
    parameter int unsigned ERROR_LIMIT        = 4,
    parameter int unsigned ERROR_WINDOW       = 65536,
    parameter int unsigned BACKOFF_STEP       = 4,
    parameter int unsigned PROG_TIMEOUT       = 4096
) (
    input logic           clk,
    input logic           reset,
    dcm_ramp_scheduler_if.slave bus
);
    localparam int TMO_W = $clog2(PROG_TIMEOUT + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam mult_t MIN_M  = mult_t'(MINIMUM_MULTIPLIER);
    localparam mult_t MAX_M  = mult_t'(MAXIMUM_MULTIPLIER);
    localparam mult_t INIT_M = mult_t'(INITIAL_MULTIPLIER);

    logic [2:0]       state_q, state_d;
    mult_t            target_q, target_d;
    mult_t            cur_q, cur_d;
    mult_t            prog_mult_q, prog_mult_d;
    mult_t            ceil_q, ceil_d;
    logic             prog_ready_q, prog_ready_d;
    logic             fault_q, fault_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [SET_W-1:0] settle_q, settle_d;

    logic  limit_hit, backoff;
    wide_t step_sum;
    mult_t step_next, backoff_cand, backoff_ceil, latch_ceil;

    dcm_error_window #(
        .ERROR_LIMIT  (ERROR_LIMIT),
        .ERROR_WINDOW (ERROR_WINDOW)
    ) u_error_window (
        .clk           (clk),
        .reset         (reset),
        .hw_error_i    (bus.hw_error_i),
        .clear_count_i (backoff),
        .limit_hit_o   (limit_hit)
    );

    // A cluster seen mid-handshake waits until the step has landed.
    assign backoff  = limit_hit && (state_q == ST_IDLE || state_q == ST_SETTLE);
    assign step_sum = {1'b0, cur_q} + wide_t'(STEP_SIZE);

    always_comb begin
        if (target_q <= cur_q)
            step_next = target_q;
        else if (step_sum >= {1'b0, target_q})
            step_next = target_q;
        else
            step_next = step_sum[MULT_W-1:0];
    end

    always_comb begin
        if ({1'b0, cur_q} < wide_t'(MINIMUM_MULTIPLIER + BACKOFF_STEP))
            backoff_cand = MIN_M;
        else
            backoff_cand = cur_q - mult_t'(BACKOFF_STEP);
        backoff_ceil = (backoff_cand < ceil_q) ? backoff_cand : ceil_q;
        latch_ceil   = backoff ? backoff_ceil : ceil_q;
    end

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        cur_d        = cur_q;
        prog_mult_d  = prog_mult_q;
        ceil_d       = ceil_q;
        prog_ready_d = prog_ready_q;
        fault_d      = fault_q;
        tmo_d        = tmo_q;
        settle_d     = settle_q;

        if (bus.target_valid_i)
            target_d = clamp_mult(bus.target_mult_i, MIN_M, latch_ceil);

        if (backoff) begin
            ceil_d   = backoff_ceil;
            settle_d = '0;
            state_d  = ST_IDLE;
            if (!bus.target_valid_i && target_q > backoff_ceil)
                target_d = backoff_ceil;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (target_q != cur_q)
                        state_d = ST_STEP;
                end
                ST_STEP: begin
                    // Target may have been rewritten to current on the way in.
                    if (target_q == cur_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        prog_mult_d  = step_next;
                        prog_ready_d = 1'b1;
                        tmo_d        = TMO_W'(PROG_TIMEOUT - 1);
                        state_d      = ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (tmo_q != '0)
                        tmo_d = tmo_q - TMO_W'(1);
                    if (bus.prog_busy_i) begin
                        prog_ready_d = 1'b0;
                        state_d      = ST_WAIT_DONE;
                    end else if (tmo_q == '0) begin
                        prog_ready_d = 1'b0;
                        fault_d      = 1'b1;
                        state_d      = ST_HALT;
                    end
                end
                ST_WAIT_DONE: begin
                    if (tmo_q != '0)
                        tmo_d = tmo_q - TMO_W'(1);
                    if (!bus.prog_busy_i && bus.dcm_locked_i) begin
                        cur_d    = prog_mult_q;
                        settle_d = SET_W'(SETTLE_CYCLES - 1);
                        state_d  = ST_SETTLE;
                    end else if (tmo_q == '0) begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == '0)
                        state_d = ST_IDLE;
                    else
                        settle_d = settle_q - SET_W'(1);
                end
                ST_HALT: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            target_q     <= INIT_M;
            cur_q        <= INIT_M;
            prog_mult_q  <= INIT_M;
            ceil_q       <= MAX_M;
            prog_ready_q <= 1'b0;
            fault_q      <= 1'b0;
            tmo_q        <= '0;
            settle_q     <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            cur_q        <= cur_d;
            prog_mult_q  <= prog_mult_d;
            ceil_q       <= ceil_d;
            prog_ready_q <= prog_ready_d;
            fault_q      <= fault_d;
            tmo_q        <= tmo_d;
            settle_q     <= settle_d;
        end
    end

    assign bus.prog_multiplier_o    = prog_mult_q;
    assign bus.prog_ready_o         = prog_ready_q;
    assign bus.current_multiplier_o = cur_q;
    assign bus.ceiling_o            = ceil_q;
    assign bus.busy_o               = (state_q != ST_IDLE);
    assign bus.fault_o              = fault_q;
endmodule
